mem2_arbiter: RTL

Arbiter for the shared data-memory port (port 2) of the OTTER MCU. It lets the CPU load/store path and a DMA engine share the port. The CPU normally has priority, and a starvation counter guarantees the DMA engine a slot. Reads complete one cycle after grant, since the memory reads synchronously. The registered read owner routes returning data back to the requester that issued the read.

---
 rtl/mem2_arbiter.sv | 72 +++++++
 1 files changed

// File: rtl/mem2_arbiter.sv
// mem2_arbiter: shares OTTER data-memory port 2 between the CPU and a DMA engine.
// The CPU has priority, but a starvation counter guarantees the DMA a slot.
module mem2_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sign,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic [1:0]        dma_size,
    input  logic              dma_sign,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    owner_t     rd_owner_q, rd_owner_d;
    logic       sel_dma;

    always_comb begin
        // rst_n gates the grants so nothing reaches memory while reset is held
        sel_dma      = rst_n & dma_req & (~cpu_req | (starve_cnt_q >= LIMIT));
        dma_gnt      = sel_dma;
        cpu_gnt      = rst_n & cpu_req & ~sel_dma;
        mem_addr     = sel_dma ? dma_addr : cpu_addr;
        mem_wdata    = sel_dma ? dma_wdata : cpu_wdata;
        mem_size     = sel_dma ? dma_size : cpu_size;
        mem_sign     = sel_dma ? dma_sign : cpu_sign;
        mem_read     = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
        mem_write    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
        cpu_rvalid   = rst_n & (rd_owner_q == OWN_CPU);
        dma_rvalid   = rst_n & (rd_owner_q == OWN_DMA);
        cpu_rdata    = mem_rdata;
        dma_rdata    = mem_rdata;
        starve_cnt_d = (dma_req & ~dma_gnt) ? starve_cnt_q + {3'b000, starve_cnt_q != 4'hf} : 4'h0;
        rd_owner_d   = (cpu_gnt & ~cpu_we) ? OWN_CPU : (dma_gnt & ~dma_we) ? OWN_DMA : OWN_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'h0;
            rd_owner_q   <= OWN_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
        end
    end
endmodule
